// File: rtl/uart_tx_serializer_if.sv
// FIFO read-port bundle between the TX FIFO and the UART serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    // Handshake: a one-cycle fifo_rd_en pops one entry, and only when fifo_empty was low at the
    // consumer's decision; fifo_rd_data holds that entry from the cycle after the pop.
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rd_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rd_data
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte per frame from the TX FIFO and shifts it out as
// start, LSB-first data, optional parity, and one or two stop bits.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tx_en,
    uart_tx_serializer_if.master fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done,
    output logic [2:0]           fsm_state
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int IDX_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_bit;
    logic                  bit_end;
    logic                  data_last;
    logic                  stop_last;
    logic                  on_line;

    assign bit_end   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign data_last = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign stop_last = (bit_idx == IDX_W'(STOP_BITS - 1));
    assign on_line   = (state == S_START) || (state == S_DATA) ||
                       (state == S_PARITY) || (state == S_STOP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (tx_en && !fifo.fifo_empty) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA: begin
                if (bit_end && data_last) begin
                    state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP:   if (bit_end && stop_last) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Line and strobes decode from state and registers only, so reset forces them at once.
    always_comb begin
        tx = 1'b1;
        case (state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_reg[0];
            S_PARITY: tx = parity_bit;
            default:  tx = 1'b1;
        endcase
    end

    assign busy            = (state != S_IDLE);
    assign fifo.fifo_rd_en = (state == S_FETCH);
    assign fsm_state       = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= (state == S_STOP) && bit_end && stop_last;

            if (on_line && !bit_end) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
            end

            // The FIFO presents the popped word during LOAD.
            if (state == S_LOAD) begin
                shift_reg  <= fifo.fifo_rd_data;
                parity_bit <= (^fifo.fifo_rd_data) ^ (PARITY_ODD != 0);
            end else if ((state == S_DATA) && bit_end) begin
                shift_reg <= shift_reg >> 1;
            end

            if ((state == S_DATA) && bit_end) begin
                bit_idx <= data_last ? '0 : bit_idx + 1'b1;
            end else if ((state == S_STOP) && bit_end) begin
                bit_idx <= stop_last ? '0 : bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parameter variants share one FIFO model; one is active at a time.
module tb_uart_tx_serializer;
    localparam int NI          = 4;
    localparam int P_EN [NI]   = '{0, 1, 1, 0};
    localparam int P_ODD [NI]  = '{0, 0, 1, 0};
    localparam int P_SB [NI]   = '{1, 1, 1, 2};

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [NI-1:0] tx_en = '0;
    logic [NI-1:0] tx;
    logic [NI-1:0] busy;
    logic [NI-1:0] tx_done;
    logic [NI-1:0] rd_en;
    logic [2:0]    st [NI];

    logic          fifo_empty = 1'b1;
    logic [7:0]    fifo_rd_data = '0;
    logic [7:0]    fifo_q[$];
    logic [8:0]    exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int pop_err = 0;
    int pop_cnt [NI] = '{0, 0, 0, 0};
    int done_cnt [NI] = '{0, 0, 0, 0};
    logic chk_gap = 1'b0;
    int gap_t0 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en != '0) begin
            if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
            else pop_err <= pop_err + 1;
        end
    end

    always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rd_en[i]) pop_cnt[i] <= pop_cnt[i] + 1;
            if (tx_done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int PE = P_EN[g];
        localparam int SB = P_SB[g];
        localparam int FL = 1 + 8 + PE + SB;
        int prev_end = -1000;

        uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();
        assign bus.fifo_empty   = fifo_empty;
        assign bus.fifo_rd_data = fifo_rd_data;
        assign rd_en[g]         = bus.fifo_rd_en;

        uart_tx_serializer #(
            .CLKS_PER_BIT(4),
            .DATA_WIDTH  (8),
            .PARITY_EN   (P_EN[g]),
            .PARITY_ODD  (P_ODD[g]),
            .STOP_BITS   (P_SB[g])
        ) dut (
            .clk      (clk),
            .rstn     (rstn),
            .tx_en    (tx_en[g]),
            .fifo     (bus.master),
            .tx       (tx[g]),
            .busy     (busy[g]),
            .tx_done  (tx_done[g]),
            .fsm_state(st[g])
        );

        // Frame monitor: decodes each frame cycle by cycle and scores it against exp_q.
        initial begin : mon
            logic [11:0] bits;
            logic        stable;
            logic        aborted;
            logic [8:0]  obs;
            int          t0;
            forever begin
                @(negedge clk);
                if (rstn && tx[g] == 1'b0) begin
                    t0 = cyc;
                    bits = '0;
                    stable = 1'b1;
                    aborted = 1'b0;
                    if (chk_gap && prev_end > gap_t0) check("b2b_gap", 32'(t0 - prev_end - 1), 32'd3);
                    check("busy_in_frame", 32'(busy[g]), 32'd1);
                    for (int c = 0; c < FL * 4; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!rstn) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c % 4 == 0) bits[c / 4] = tx[g];
                        else if (tx[g] != bits[c / 4]) stable = 1'b0;
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        check("tx_done_at_end", 32'(tx_done[g]), 32'd1);
                        check("busy_low_at_done", 32'(busy[g]), 32'd0);
                        check("bits_stable", 32'(stable), 32'd1);
                        for (int s = 0; s < SB; s++) check("stop_bit", 32'(bits[FL - 1 - s]), 32'd1);
                        prev_end = t0 + FL * 4 - 1;
                        obs = {(PE != 0) ? bits[9] : 1'b0, bits[8:1]};
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL unexpected_frame: got %0h expected none", obs);
                        end else begin
                            check("frame", 32'(obs), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy != '0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_total++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", name, exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx_low(input int g, input string name);
        int n;
        n = 0;
        while (tx[g] !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL %s_no_start: got tx=%0b expected 0", name, tx[g]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    initial begin : stim
        int viol;
        int p0;
        int d0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_tx", 32'(tx[i]), 32'd1);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_rd_en", 32'(rd_en[i]), 32'd0);
            check("rst_tx_done", 32'(tx_done[i]), 32'd0);
            check("rst_state", 32'(st[i]), 32'd0);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Empty FIFO with tx_en high: nothing may move.
        tx_en[0] = 1'b1;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) viol++;
        end
        check("empty_idle", 32'(viol), 32'd0);
        check("empty_no_pop", 32'(pop_cnt[0]), 32'd0);
        tx_en[0] = 1'b0;

        // Single byte, no parity, one stop bit.
        p0 = pop_cnt[0];
        d0 = done_cnt[0];
        fifo_q.push_back(8'hA5);
        exp_q.push_back(9'h0A5);
        tx_en[0] = 1'b1;
        wait_idle("single");
        check("single_pops", 32'(pop_cnt[0] - p0), 32'd1);
        check("single_done", 32'(done_cnt[0] - d0), 32'd1);
        tx_en[0] = 1'b0;

        // Even parity.
        fifo_q.push_back(8'h07);
        fifo_q.push_back(8'h03);
        exp_q.push_back(9'h107);
        exp_q.push_back(9'h003);
        tx_en[1] = 1'b1;
        wait_idle("par_even");
        tx_en[1] = 1'b0;

        // Odd parity.
        fifo_q.push_back(8'h07);
        fifo_q.push_back(8'h03);
        exp_q.push_back(9'h007);
        exp_q.push_back(9'h103);
        tx_en[2] = 1'b1;
        wait_idle("par_odd");
        tx_en[2] = 1'b0;

        // Two stop bits.
        fifo_q.push_back(8'h3C);
        exp_q.push_back(9'h03C);
        tx_en[3] = 1'b1;
        wait_idle("stop2");
        tx_en[3] = 1'b0;

        // Back-to-back from a preloaded FIFO.
        p0 = pop_cnt[0];
        d0 = done_cnt[0];
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h55);
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h0FF);
        exp_q.push_back(9'h055);
        repeat (2) @(negedge clk);
        gap_t0 = cyc;
        chk_gap = 1'b1;
        tx_en[0] = 1'b1;
        wait_idle("b2b");
        chk_gap = 1'b0;
        tx_en[0] = 1'b0;
        check("b2b_pops", 32'(pop_cnt[0] - p0), 32'd3);
        check("b2b_done", 32'(done_cnt[0] - d0), 32'd3);

        // tx_en dropped mid-frame: frame completes, second byte stays queued.
        p0 = pop_cnt[0];
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h6B);
        exp_q.push_back(9'h05A);
        tx_en[0] = 1'b1;
        wait_tx_low(0, "en_drop");
        repeat (8) @(negedge clk);
        tx_en[0] = 1'b0;
        wait_idle("en_drop");
        repeat (20) @(negedge clk);
        check("en_drop_pops", 32'(pop_cnt[0] - p0), 32'd1);
        check("en_drop_fifo_left", 32'(fifo_q.size()), 32'd1);
        exp_q.push_back(9'h06B);
        tx_en[0] = 1'b1;
        wait_idle("en_resume");
        tx_en[0] = 1'b0;

        // Reset during data bit 3; the popped byte is lost, the next one goes out cleanly.
        p0 = pop_cnt[0];
        fifo_q.push_back(8'h12);
        fifo_q.push_back(8'h34);
        exp_q.push_back(9'h034);
        tx_en[0] = 1'b1;
        wait_tx_low(0, "rst_mid");
        repeat (17) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx[0]), 32'd1);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        check("rst_mid_rd_en", 32'(rd_en[0]), 32'd0);
        check("rst_mid_state", 32'(st[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
        wait_idle("rst_recover");
        tx_en[0] = 1'b0;
        check("rst_mid_pops", 32'(pop_cnt[0] - p0), 32'd2);

        check("pops_inst1", 32'(pop_cnt[1]), 32'd2);
        check("pops_inst2", 32'(pop_cnt[2]), 32'd2);
        check("pops_inst3", 32'(pop_cnt[3]), 32'd1);
        check("pop_while_empty", 32'(pop_err), 32'd0);
        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        check("leftover_fifo", 32'(fifo_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
